// File: rtl/emd_sift_stage.sv
// Streaming EMD sifting stage: power-of-two boxcar mean (residue) and centre-aligned,
// saturated IMF = x[k-L/2] - mean. Valid-qualified so stages can be chained directly.
module emd_sift_stage #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [WIDTH-1:0] Xin,
  input  logic                    Xin_valid,
  output logic signed [WIDTH-1:0] Rout,
  output logic signed [WIDTH-1:0] IMFout,
  output logic                    Out_valid
);

  localparam int unsigned L  = 2 ** WIN_LOG2;
  localparam int unsigned SW = WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] HALF = WIN_LOG2'(L / 2);
  localparam logic [WIN_LOG2-1:0] LAST = WIN_LOG2'(L - 1);

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e                  r_state;
  logic [WIN_LOG2-1:0]     r_wptr;
  logic [WIN_LOG2-1:0]     r_cnt;
  logic signed [SW-1:0]    r_sum;
  logic signed [WIDTH-1:0] r_buf [L];
  logic signed [WIDTH-1:0] r_rout;
  logic signed [WIDTH-1:0] r_imf;
  logic                    r_valid;

  logic [WIN_LOG2-1:0]     w_cidx;
  logic signed [WIDTH-1:0] w_old;
  logic signed [WIDTH-1:0] w_centre;
  logic signed [SW-1:0]    w_x_ext;
  logic signed [SW-1:0]    w_old_ext;
  logic signed [SW-1:0]    w_sum_next;
  logic signed [WIDTH-1:0] w_rout_next;
  logic signed [WIDTH:0]   w_diff;
  logic signed [WIDTH-1:0] w_imf_next;
  logic                    w_fire;

  // Oldest tap is read before this cycle's write; the centre tap never aliases the write slot.
  assign w_cidx     = r_wptr - HALF;
  assign w_old      = (r_state == StRun) ? r_buf[r_wptr] : '0;
  assign w_centre   = r_buf[w_cidx];
  assign w_x_ext    = {{WIN_LOG2{Xin[WIDTH-1]}}, Xin};
  assign w_old_ext  = {{WIN_LOG2{w_old[WIDTH-1]}}, w_old};
  assign w_sum_next = r_sum + w_x_ext - w_old_ext;

  // Dropping the low bits of the sum is an arithmetic shift, i.e. floor division by L.
  assign w_rout_next = w_sum_next[SW-1:WIN_LOG2];
  assign w_diff      = {w_centre[WIDTH-1], w_centre} - {w_rout_next[WIDTH-1], w_rout_next};
  assign w_fire      = Xin_valid && ((r_state == StRun) || (r_cnt == LAST));

  always_comb begin
    w_imf_next = w_diff[WIDTH-1:0];
    if (w_diff[WIDTH] != w_diff[WIDTH-1]) begin
      w_imf_next = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Sample RAM deliberately has no reset.
  always_ff @(posedge CLK) begin
    if (Xin_valid && !RST) begin
      r_buf[r_wptr] <= Xin;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StFill;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_rout  <= '0;
      r_imf   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_fire;
      if (Xin_valid) begin
        r_sum  <= w_sum_next;
        r_wptr <= r_wptr + WIN_LOG2'(1);
        if (r_state == StFill) begin
          if (r_cnt == LAST) begin
            r_state <= StRun;
          end else begin
            r_cnt <= r_cnt + WIN_LOG2'(1);
          end
        end
      end
      if (w_fire) begin
        r_rout <= w_rout_next;
        r_imf  <= w_imf_next;
      end
    end
  end

  assign Rout      = r_rout;
  assign IMFout    = r_imf;
  assign Out_valid = r_valid;

endmodule
